// File: rtl/record_serializer.sv
// record_serializer: buffers parsed records in a FIFO and serialises each one as a header word plus payload words.
module record_serializer #(
    parameter int REC_W = 296,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [0:REC_W-1]           rec_in,
    input  logic                       rec_in_val,
    output logic                       rec_in_ready,
    input  logic                       rec_in_lost,
    output logic [31:0]                word_out,
    output logic                       word_out_val,
    input  logic                       word_out_ready,
    output logic                       word_out_last,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int PAY_BEATS = (REC_W + 31) / 32;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = PAY_BEATS > 1 ? $clog2(PAY_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PAY_BEATS - 1);
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
    state_t state;
    logic [0:REC_W-1] recMem [DEPTH];
    logic lostMem [DEPTH];
    logic [15:0] cntMem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [15:0] recCnt;
    logic [BW-1:0] beat;
    logic [0:REC_W-1] hold;
    logic [0:PAY_BEATS*32-1] padded;
    logic [31:0] payWords [PAY_BEATS];
    logic push, pop;
    logic [CW-1:0] nextCount;
    always_comb begin
        padded = '0;
        padded[0:REC_W-1] = hold;
    end
    for (genvar k = 0; k < PAY_BEATS; k++) begin : g_words
        assign payWords[k] = padded[32*k +: 32];
    end
    assign push = rec_in_val && rec_in_ready;
    assign pop = fifo_count != '0 &&
                 (state == IDLE || (state == PAY && beat == LAST_BEAT && word_out_ready));
    assign nextCount = fifo_count + CW'(push) - CW'(pop);
    // storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        if (push) begin
            recMem[wrPtr] <= rec_in;
            lostMem[wrPtr] <= rec_in_lost;
            cntMem[wrPtr] <= recCnt;
        end
        if (pop) hold <= recMem[rdPtr];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wrPtr <= '0;
            rdPtr <= '0;
            recCnt <= '0;
            beat <= '0;
            fifo_count <= '0;
            rec_in_ready <= 1'b0;
            word_out <= '0;
            word_out_val <= 1'b0;
            word_out_last <= 1'b0;
        end else begin
            fifo_count <= nextCount;
            rec_in_ready <= nextCount < CW'(DEPTH);
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
                recCnt <= recCnt + 1'b1;
            end
            if (state == HDR && word_out_ready) begin
                state <= PAY;
                beat <= '0;
                word_out <= payWords[0];
                word_out_last <= PAY_BEATS == 1;
            end else if (state == PAY && word_out_ready) begin
                if (beat == LAST_BEAT) begin
                    state <= IDLE;
                    word_out <= '0;
                    word_out_val <= 1'b0;
                    word_out_last <= 1'b0;
                end else begin
                    beat <= beat + 1'b1;
                    word_out <= payWords[beat + 1'b1];
                    word_out_last <= beat + 1'b1 == LAST_BEAT;
                end
            end
            // a pop overrides the end-of-record idle so records follow without a bubble
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
                state <= HDR;
                word_out <= {lostMem[rdPtr], 15'b0, cntMem[rdPtr]};
                word_out_val <= 1'b1;
                word_out_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_record_serializer.sv
// tb_record_serializer: directed table-driven checks of record_serializer against a word-stream model.
module tb_record_serializer;
    localparam int REC_W = 296;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [0:REC_W-1] rec_in = '0;
    logic rec_in_val = 1'b0;
    logic rec_in_ready;
    logic rec_in_lost = 1'b0;
    logic [31:0] word_out;
    logic word_out_val;
    logic word_out_ready;
    logic word_out_last;
    logic [2:0] fifo_count;
    int total = 0;
    int bad = 0;
    int rdyMode = 0;
    int cyc = 0;
    int stabViol = 0;
    bit stall = 0;
    logic [31:0] stWord;
    logic stLast;
    logic [32:0] capQ [$];
    int capCyc [$];
    logic [32:0] expQ [$];
    logic [15:0] mCnt = '0;
    typedef struct {logic [31:0] word; logic last;} vec_t;
    typedef struct {logic lost; logic [31:0] hdr;} hv_t;
    vec_t tbl [11];
    hv_t tbl2 [3];

    record_serializer #(.REC_W(REC_W), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .rec_in(rec_in), .rec_in_val(rec_in_val),
        .rec_in_ready(rec_in_ready), .rec_in_lost(rec_in_lost), .word_out(word_out),
        .word_out_val(word_out_val), .word_out_ready(word_out_ready),
        .word_out_last(word_out_last), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        word_out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            word_out_ready = rdyMode == 2 ? 1'($urandom % 2) : rdyMode == 1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            capQ.delete();
            capCyc.delete();
            stall = 0;
        end else begin
            if (stall && (word_out_val !== 1'b1 || word_out !== stWord || word_out_last !== stLast))
                stabViol++;
            if (word_out_val && word_out_ready) begin
                capQ.push_back({word_out_last, word_out});
                capCyc.push_back(cyc);
            end
            stall = word_out_val && !word_out_ready;
            stWord = word_out;
            stLast = word_out_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] payWord(input logic [0:REC_W-1] r, input int k);
        logic [31:0] w;
        for (int j = 0; j < 32; j++) w[31-j] = (32*k + j < REC_W) ? r[32*k + j] : 1'b0;
        return w;
    endfunction

    task automatic addExp(input logic [0:REC_W-1] r, input logic l);
        expQ.push_back({1'b0, l, 15'b0, mCnt});
        for (int k = 0; k < 10; k++) expQ.push_back({k == 9, payWord(r, k)});
        mCnt++;
    endtask

    task automatic pushRec(input logic [0:REC_W-1] r, input logic l);
        bit ok = 0;
        rec_in = r;
        rec_in_lost = l;
        rec_in_val = 1'b1;
        for (int n = 0; n < 400 && !ok; n++) begin
            ok = rec_in_ready;
            @(posedge clk);
            #1;
        end
        rec_in_val = 1'b0;
        chk("push accepted", 64'(ok), 64'd1);
        if (ok) addExp(r, l);
    endtask

    function automatic logic [0:REC_W-1] rndRec();
        logic [0:REC_W-1] r;
        for (int c = 0; c < 9; c++) r[32*c +: 32] = $urandom;
        r[288 +: 8] = 8'($urandom);
        return r;
    endfunction

    task automatic doReset();
        reset = 1'b1;
        rec_in_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expQ.delete();
        mCnt = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic waitFor(input int n, input int bound);
        for (int k = 0; k < bound && capQ.size() < n; k++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic cmpExp(input string nm);
        chk({nm, " words"}, 64'(capQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < capQ.size(); i++)
            chk($sformatf("%s w%0d", nm, i), 64'(capQ[i]), 64'(expQ[i]));
        chk({nm, " stable"}, 64'(stabViol), 64'd0);
    endtask

    initial begin
        logic [0:REC_W-1] r, r6, ra;
        int gaps;
        tbl[0] = '{32'h00000000, 1'b0};
        for (int k = 0; k < 9; k++)
            tbl[k+1] = '{{8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)}, 1'b0};
        tbl[10] = '{32'h24000000, 1'b1};
        tbl2[0] = '{1'b0, 32'h00000000};
        tbl2[1] = '{1'b1, 32'h80000001};
        tbl2[2] = '{1'b0, 32'h00000002};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst val", 64'(word_out_val), 64'd0);
        chk("rst last", 64'(word_out_last), 64'd0);
        chk("rst word", 64'(word_out), 64'd0);
        chk("rst count", 64'(fifo_count), 64'd0);
        chk("rst ready", 64'(rec_in_ready), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready after release", 64'(rec_in_ready), 64'd1);

        // single record, byte n = n
        doReset();
        rdyMode = 1;
        repeat (2) @(posedge clk);
        #1;
        r = '0;
        for (int n = 0; n < 37; n++) r[8*n +: 8] = 8'(n);
        pushRec(r, 1'b0);
        chk("lat t", 64'(word_out_val), 64'd0);
        @(posedge clk);
        #1;
        chk("lat t+1", 64'(word_out_val), 64'd1);
        chk("lat hdr", 64'(word_out), 64'd0);
        waitFor(11, 200);
        chk("single words", 64'(capQ.size()), 64'd11);
        for (int i = 0; i < 11 && i < capQ.size(); i++)
            chk($sformatf("single w%0d", i), 64'(capQ[i]), 64'({tbl[i].last, tbl[i].word}));

        // back-to-back with lost flag
        doReset();
        for (int i = 0; i < 3; i++) pushRec(rndRec(), tbl2[i].lost);
        waitFor(33, 300);
        cmpExp("b2b");
        for (int i = 0; i < 3 && 11*i < capQ.size(); i++)
            chk($sformatf("b2b hdr%0d", i), 64'(capQ[11*i][31:0]), 64'(tbl2[i].hdr));
        gaps = 0;
        for (int i = 1; i < capCyc.size(); i++) if (capCyc[i] - capCyc[i-1] != 1) gaps++;
        chk("b2b gapless", 64'(gaps), 64'd0);

        // back-pressure until full
        rdyMode = 0;
        doReset();
        for (int i = 0; i < 5; i++) pushRec(rndRec(), 1'(i == 2));
        r6 = rndRec();
        rec_in = r6;
        rec_in_lost = 1'b0;
        rec_in_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("full ready", 64'(rec_in_ready), 64'd0);
            chk("full count", 64'(fifo_count), 64'd4);
            chk("full val", 64'(word_out_val), 64'd1);
            chk("full hdr", 64'(word_out), 64'd0);
        end
        chk("full nothing sent", 64'(capQ.size()), 64'd0);
        rdyMode = 1;
        pushRec(r6, 1'b0);
        waitFor(66, 1000);
        cmpExp("full");

        // random ready over 20 records
        rdyMode = 2;
        doReset();
        for (int i = 0; i < 20; i++) pushRec(rndRec(), 1'($urandom % 2));
        waitFor(220, 3000);
        cmpExp("rand");

        // counter wrap
        rdyMode = 1;
        doReset();
        force dut.recCnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.recCnt;
        mCnt = 16'hFFFF;
        pushRec(rndRec(), 1'b0);
        pushRec(rndRec(), 1'b0);
        waitFor(22, 300);
        cmpExp("wrap");
        if (capQ.size() >= 22) begin
            chk("wrap hdr ffff", 64'(capQ[0][31:0]), 64'h0000FFFF);
            chk("wrap hdr 0000", 64'(capQ[11][31:0]), 64'h00000000);
        end

        // async reset mid-payload
        doReset();
        ra = rndRec();
        pushRec(ra, 1'b0);
        pushRec(rndRec(), 1'b0);
        for (int k = 0; k < 100 && capQ.size() < 5; k++) begin
            @(posedge clk);
            #1;
        end
        chk("abort at beat4", 64'(word_out), 64'(payWord(ra, 4)));
        #1;
        reset = 1'b1;
        #1;
        chk("abort val", 64'(word_out_val), 64'd0);
        chk("abort last", 64'(word_out_last), 64'd0);
        chk("abort count", 64'(fifo_count), 64'd0);
        chk("abort ready", 64'(rec_in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        expQ.delete();
        mCnt = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort no resume val", 64'(word_out_val), 64'd0);
        chk("abort no resume words", 64'(capQ.size()), 64'd0);
        pushRec(rndRec(), 1'b1);
        waitFor(11, 200);
        cmpExp("after abort");
        if (capQ.size() > 0) chk("after abort hdr", 64'(capQ[0][31:0]), 64'h80000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
